// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_pkg
// Description : Shared defaults and next-PC source encoding for pc_unit.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

  localparam int unsigned DEF_PC_W      = 5;
  localparam int unsigned DEF_INC       = 1;
  localparam int unsigned DEF_RESET_VEC = 0;
  localparam int unsigned DEF_TRAP_VEC  = (2 ** DEF_PC_W) - 1;
  localparam int unsigned DEF_RAS_DEPTH = 4;

  // Next-PC sources, listed from highest to lowest priority.
  typedef enum logic [2:0] {
    SRC_TRAP = 3'd0,
    SRC_RET  = 3'd1,
    SRC_CALL = 3'd2,
    SRC_JUMP = 3'd3,
    SRC_BR   = 3'd4,
    SRC_HOLD = 3'd5,
    SRC_INC  = 3'd6
  } pc_src_e;

endpackage
`default_nettype wire

// File: rtl/pc_ras.sv
`default_nettype none
// ============================================================================
// Module      : pc_ras
// Description : Circular return-address stack. A push while full silently
//               overwrites the oldest entry; count saturates at DEPTH.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_ras #(
  parameter int unsigned W     = 5,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     push_data,
  output logic [W-1:0]     top,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] cnt_q;

  // Pointer and occupancy; pointer wraps naturally because DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (push) begin
      wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (!full) cnt_q <= cnt_q + CNT_W'(1);
    end else if (pop && !empty) begin
      wr_ptr_q <= wr_ptr_q - PTR_W'(1);
      cnt_q    <= cnt_q - CNT_W'(1);
    end
  end

  // Entry storage; contents are don't-care after reset since count gates use.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign top   = mem_q[wr_ptr_q - PTR_W'(1)];
  assign count = cnt_q;
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(DEPTH));

endmodule
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_unit
// Description : Fetch-stage program counter with priority next-PC selection,
//               return-address stack and sticky RAS error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned PC_W      = DEF_PC_W,
  parameter int unsigned INC       = DEF_INC,
  parameter int unsigned RESET_VEC = DEF_RESET_VEC,
  parameter int unsigned TRAP_VEC  = (2 ** PC_W) - 1,
  parameter int unsigned RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            br_taken,
  input  logic            jump,
  input  logic            call,
  input  logic            ret,
  input  logic            trap,
  input  logic [PC_W-1:0] target,
  input  logic            clr_err,
  output logic [PC_W-1:0] pc,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_ovf,
  output logic            ras_unf
);

  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [PC_W-1:0] c_inc = PC_W'(INC);

  logic [PC_W-1:0]  pc_q, pc_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             ras_push, ras_pop;
  logic             ovf_evt, unf_evt;
  logic [PC_W-1:0]  ras_top;
  logic [CNT_W-1:0] ras_cnt;
  pc_src_e          src;

  pc_ras #(
    .W     (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_q + c_inc),
    .top       (ras_top),
    .count     (ras_cnt),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  // Priority encoder: exactly one source wins each cycle.
  always_comb begin
    src = SRC_INC;
    if (trap)          src = SRC_TRAP;
    else if (ret)      src = SRC_RET;
    else if (call)     src = SRC_CALL;
    else if (jump)     src = SRC_JUMP;
    else if (br_taken) src = SRC_BR;
    else if (stall)    src = SRC_HOLD;
  end

  // Next-PC mux and stack control for the winning source.
  always_comb begin
    pc_d     = pc_q + c_inc;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    ovf_evt  = 1'b0;
    unf_evt  = 1'b0;
    case (src)
      SRC_TRAP: pc_d = PC_W'(TRAP_VEC);
      SRC_RET: begin
        if (ras_cnt != '0) begin
          pc_d    = ras_top;
          ras_pop = 1'b1;
        end else begin
          pc_d    = target;
          unf_evt = 1'b1;
        end
      end
      SRC_CALL: begin
        pc_d     = target;
        ras_push = 1'b1;
        ovf_evt  = (ras_cnt == CNT_W'(RAS_DEPTH));
      end
      SRC_JUMP, SRC_BR: pc_d = target;
      SRC_HOLD: pc_d = pc_q;
      default:  pc_d = pc_q + c_inc;
    endcase
  end

  // Sticky flags: a coincident event beats clr_err.
  always_comb begin
    ovf_d = (ovf_q & ~clr_err) | ovf_evt;
    unf_d = (unf_q & ~clr_err) | unf_evt;
  end

  // PC and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= PC_W'(RESET_VEC);
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign pc      = pc_q;
  assign ras_ovf = ovf_q;
  assign ras_unf = unf_q;

endmodule
`default_nettype wire
